// File: rtl/wb_mem_arbiter.sv
// Two-master / one-slave Wishbone classic arbiter for the instruction and data
// ports, with round-robin grant locked per bus cycle and a slave-response watchdog.
module wb_mem_arbiter #(
    parameter int TO_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] im_addr_i,
    input  logic        im_cyc_i,
    input  logic        im_stb_i,
    output logic [31:0] im_dat_o,
    output logic        im_ack_o,
    output logic        im_err_o,

    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_dat_i,
    input  logic [3:0]  dm_sel_i,
    input  logic        dm_we_i,
    input  logic        dm_cyc_i,
    input  logic        dm_stb_i,
    output logic [31:0] dm_dat_o,
    output logic        dm_ack_o,
    output logic        dm_err_o,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i,
    input  logic        s_err_i,

    output logic [1:0]  grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        TERM  = 2'd3
    } state_t;

    localparam logic [15:0] TO_LAST = 16'(TO_CYCLES - 1);

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_grant;
    logic [1:0]  w_nextGrant;
    logic        r_lastData;
    logic        w_nextLastData;
    logic [15:0] r_wdCount;
    logic [15:0] w_nextWdCount;
    logic        w_gntCyc;
    logic        w_gntStb;

    assign im_dat_o = s_dat_i;
    assign dm_dat_o = s_dat_i;
    assign grant_o  = r_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_grant    <= 2'b00;
            r_lastData <= 1'b1;
            r_wdCount  <= 16'd0;
        end else begin
            r_state    <= w_nextState;
            r_grant    <= w_nextGrant;
            r_lastData <= w_nextLastData;
            r_wdCount  <= w_nextWdCount;
        end
    end

    // Bus muxing, response routing and next-state all derive from the registered state.
    always_comb begin
        w_nextState    = r_state;
        w_nextGrant    = r_grant;
        w_nextLastData = r_lastData;
        w_nextWdCount  = r_wdCount;
        w_gntCyc       = 1'b0;
        w_gntStb       = 1'b0;
        s_addr_o       = 32'd0;
        s_dat_o        = 32'd0;
        s_sel_o        = 4'd0;
        s_we_o         = 1'b0;
        s_cyc_o        = 1'b0;
        s_stb_o        = 1'b0;
        im_ack_o       = 1'b0;
        im_err_o       = 1'b0;
        dm_ack_o       = 1'b0;
        dm_err_o       = 1'b0;

        case (r_state)
            IDLE: begin
                w_nextWdCount = 16'd0;
                // On a tie the master that did not own the bus last time wins.
                if (im_cyc_i && (!dm_cyc_i || r_lastData)) begin
                    w_nextState    = GNT_I;
                    w_nextGrant    = 2'b01;
                    w_nextLastData = 1'b0;
                end else if (dm_cyc_i) begin
                    w_nextState    = GNT_D;
                    w_nextGrant    = 2'b10;
                    w_nextLastData = 1'b1;
                end
            end
            GNT_I: begin
                w_gntCyc = im_cyc_i;
                w_gntStb = im_stb_i;
                s_addr_o = im_addr_i;
                s_sel_o  = 4'hF;
                im_ack_o = s_ack_i;
                im_err_o = s_err_i & ~s_ack_i;
            end
            GNT_D: begin
                w_gntCyc = dm_cyc_i;
                w_gntStb = dm_stb_i;
                s_addr_o = dm_addr_i;
                s_dat_o  = dm_dat_i;
                s_sel_o  = dm_sel_i;
                s_we_o   = dm_we_i;
                dm_ack_o = s_ack_i;
                dm_err_o = s_err_i & ~s_ack_i;
            end
            TERM: begin
                im_err_o      = r_grant[0];
                dm_err_o      = r_grant[1];
                w_nextState   = IDLE;
                w_nextGrant   = 2'b00;
                w_nextWdCount = 16'd0;
            end
            default: begin
                w_nextState   = IDLE;
                w_nextGrant   = 2'b00;
                w_nextWdCount = 16'd0;
            end
        endcase

        if (r_state == GNT_I || r_state == GNT_D) begin
            s_cyc_o = w_gntCyc;
            s_stb_o = w_gntStb;
            if (!w_gntCyc) begin
                w_nextState   = IDLE;
                w_nextGrant   = 2'b00;
                w_nextWdCount = 16'd0;
            end else if (s_ack_i || s_err_i) begin
                w_nextWdCount = 16'd0;
            end else if (w_gntStb) begin
                if (r_wdCount >= TO_LAST) begin
                    w_nextState   = TERM;
                    w_nextWdCount = 16'd0;
                end else begin
                    w_nextWdCount = r_wdCount + 16'd1;
                end
            end
        end

        // A reset in the middle of a cycle must not let a slave response leak out.
        if (rst) begin
            s_cyc_o  = 1'b0;
            s_stb_o  = 1'b0;
            im_ack_o = 1'b0;
            im_err_o = 1'b0;
            dm_ack_o = 1'b0;
            dm_err_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter with a short watchdog (TO_CYCLES = 8).
module tb_wb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] im_addr_i;
    logic        im_cyc_i;
    logic        im_stb_i;
    logic [31:0] im_dat_o;
    logic        im_ack_o;
    logic        im_err_o;
    logic [31:0] dm_addr_i;
    logic [31:0] dm_dat_i;
    logic [3:0]  dm_sel_i;
    logic        dm_we_i;
    logic        dm_cyc_i;
    logic        dm_stb_i;
    logic [31:0] dm_dat_o;
    logic        dm_ack_o;
    logic        dm_err_o;
    logic [31:0] s_addr_o;
    logic [31:0] s_dat_o;
    logic [3:0]  s_sel_o;
    logic        s_we_o;
    logic        s_cyc_o;
    logic        s_stb_o;
    logic [31:0] s_dat_i;
    logic        s_ack_i;
    logic        s_err_i;
    logic [1:0]  grant_o;

    int testCount = 0;
    int failCount = 0;

    wb_mem_arbiter #(.TO_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .im_addr_i(im_addr_i), .im_cyc_i(im_cyc_i), .im_stb_i(im_stb_i),
        .im_dat_o(im_dat_o), .im_ack_o(im_ack_o), .im_err_o(im_err_o),
        .dm_addr_i(dm_addr_i), .dm_dat_i(dm_dat_i), .dm_sel_i(dm_sel_i),
        .dm_we_i(dm_we_i), .dm_cyc_i(dm_cyc_i), .dm_stb_i(dm_stb_i),
        .dm_dat_o(dm_dat_o), .dm_ack_o(dm_ack_o), .dm_err_o(dm_err_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic imReq, input logic dmReq);
        im_cyc_i = imReq;
        im_stb_i = imReq;
        dm_cyc_i = dmReq;
        dm_stb_i = dmReq;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        rst       = 1'b1;
        im_addr_i = 32'd0;
        dm_addr_i = 32'd0;
        dm_dat_i  = 32'd0;
        dm_sel_i  = 4'd0;
        dm_we_i   = 1'b0;
        s_dat_i   = 32'd0;
        s_ack_i   = 1'b0;
        s_err_i   = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitCycles(2);
        rst = 1'b0;
        checkOutput("reset grant", 32'(grant_o), 32'h0);
        checkOutput("reset s_cyc", 32'(s_cyc_o), 32'h0);
        checkOutput("reset s_addr", s_addr_o, 32'h0);
        checkOutput("reset s_sel", 32'(s_sel_o), 32'h0);
        checkOutput("reset acks", 32'({im_ack_o, im_err_o, dm_ack_o, dm_err_o}), 32'h0);

        // Instruction-only read
        im_addr_i = 32'h100;
        applyStimulus(1'b1, 1'b0);
        checkOutput("i no grant before edge", 32'(grant_o), 32'h0);
        waitCycles(1);
        checkOutput("i grant", 32'(grant_o), 32'h1);
        checkOutput("i s_cyc", 32'(s_cyc_o), 32'h1);
        checkOutput("i s_addr", s_addr_o, 32'h100);
        checkOutput("i s_sel", 32'(s_sel_o), 32'hF);
        checkOutput("i s_we", 32'(s_we_o), 32'h0);
        checkOutput("i s_dat", s_dat_o, 32'h0);
        waitCycles(1);
        s_ack_i = 1'b1;
        s_dat_i = 32'h33;
        #1;
        checkOutput("i ack", 32'(im_ack_o), 32'h1);
        checkOutput("i dat", im_dat_o, 32'h33);
        checkOutput("i no dm ack", 32'(dm_ack_o), 32'h0);
        waitCycles(1);
        s_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        checkOutput("i released", 32'(grant_o), 32'h0);

        // Data write
        dm_addr_i = 32'h2000;
        dm_dat_i  = 32'hDEADBEEF;
        dm_sel_i  = 4'b0011;
        dm_we_i   = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("d grant", 32'(grant_o), 32'h2);
        checkOutput("d s_addr", s_addr_o, 32'h2000);
        checkOutput("d s_dat", s_dat_o, 32'hDEADBEEF);
        checkOutput("d s_sel", 32'(s_sel_o), 32'h3);
        checkOutput("d s_we", 32'(s_we_o), 32'h1);
        s_ack_i = 1'b1;
        #1;
        checkOutput("d ack", 32'(dm_ack_o), 32'h1);
        checkOutput("d no im ack", 32'(im_ack_o), 32'h0);
        waitCycles(1);
        s_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        #1;
        checkOutput("d ack pulse ends", 32'(dm_ack_o), 32'h0);
        checkOutput("d grant held until edge", 32'(grant_o), 32'h2);
        waitCycles(1);
        checkOutput("d released", 32'(grant_o), 32'h0);

        // Contention: instruction, then data, then instruction again
        dm_we_i = 1'b0;
        applyStimulus(1'b1, 1'b1);
        waitCycles(1);
        checkOutput("c1 grant instr", 32'(grant_o), 32'h1);
        s_ack_i = 1'b1;
        #1;
        checkOutput("c1 im ack", 32'(im_ack_o), 32'h1);
        checkOutput("c1 dm waits", 32'(dm_ack_o), 32'h0);
        waitCycles(1);
        s_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("c dead cycle", 32'(grant_o), 32'h0);
        waitCycles(1);
        checkOutput("c2 grant data", 32'(grant_o), 32'h2);
        s_ack_i = 1'b1;
        waitCycles(1);
        s_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        applyStimulus(1'b1, 1'b1);
        waitCycles(1);
        checkOutput("c3 grant instr", 32'(grant_o), 32'h1);
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);

        // Watchdog timeout on a data read
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("t grant", 32'(grant_o), 32'h2);
        waitCycles(7);
        checkOutput("t s_cyc still up", 32'(s_cyc_o), 32'h1);
        checkOutput("t no early err", 32'(dm_err_o), 32'h0);
        waitCycles(1);
        checkOutput("t s_cyc dropped", 32'(s_cyc_o), 32'h0);
        checkOutput("t s_stb dropped", 32'(s_stb_o), 32'h0);
        checkOutput("t dm err", 32'(dm_err_o), 32'h1);
        checkOutput("t im no err", 32'(im_err_o), 32'h0);
        s_ack_i = 1'b1;
        #1;
        checkOutput("t late ack ignored", 32'(dm_ack_o), 32'h0);
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);
        s_ack_i = 1'b0;
        #1;
        checkOutput("t err one cycle", 32'(dm_err_o), 32'h0);
        checkOutput("t grant cleared", 32'(grant_o), 32'h0);

        // Data master aborts while an instruction request is pending
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("a grant data", 32'(grant_o), 32'h2);
        applyStimulus(1'b1, 1'b1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0);
        waitCycles(1);
        checkOutput("a s_cyc low", 32'(s_cyc_o), 32'h0);
        checkOutput("a no err", 32'(dm_err_o), 32'h0);
        checkOutput("a idle", 32'(grant_o), 32'h0);
        waitCycles(1);
        checkOutput("a instr granted", 32'(grant_o), 32'h1);
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);

        // Reset in the middle of a data cycle
        dm_we_i = 1'b1;
        applyStimulus(1'b0, 1'b1);
        waitCycles(1);
        checkOutput("r grant data", 32'(grant_o), 32'h2);
        checkOutput("r stb up", 32'(s_stb_o), 32'h1);
        rst     = 1'b1;
        s_ack_i = 1'b1;
        #1;
        checkOutput("r ack blocked", 32'(dm_ack_o), 32'h0);
        waitCycles(1);
        checkOutput("r slave ctl", 32'({s_cyc_o, s_stb_o, s_we_o}), 32'h0);
        checkOutput("r slave addr", s_addr_o, 32'h0);
        checkOutput("r slave dat", s_dat_o, 32'h0);
        checkOutput("r slave sel", 32'(s_sel_o), 32'h0);
        checkOutput("r grant", 32'(grant_o), 32'h0);
        checkOutput("r master resp", 32'({im_ack_o, im_err_o, dm_ack_o, dm_err_o}), 32'h0);
        rst     = 1'b0;
        s_ack_i = 1'b0;
        applyStimulus(1'b0, 1'b0);
        waitCycles(1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
